// File: rtl/nibble_subtractor.sv
// nibble_subtractor: multi-cycle A - B, one 4-bit nibble per clock, LSB first.
// The subtraction is a + ~b + 1. The borrow chain is carried between steps in
// a one-bit carry register. Start/done handshake; flags are registered at the
// final step.
module nibble_subtractor #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateType;

   stateType         state;
   stateType         nextState;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [IW+1:0]    nibBase;
   logic [4:0]       nibSum;
   logic [WIDTH-1:0] diffNext;
   logic             accept;
   logic             lastStep;

   // A new operation is taken only when no operation is in flight.
   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign lastStep = (state == RUN) && (idx == IW'(NIB - 1));
   assign busy     = (state == RUN);
   assign done     = (state == DONE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state logic: RUN lasts NIB cycles, DONE exactly one.
   always_comb begin
      // NOTE: default first, so no path through the case leaves nextState unassigned (no latch).
      nextState = state;
      unique case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (lastStep) nextState = DONE;
         DONE:    nextState = start ? RUN : IDLE;
         default: nextState = IDLE;
      endcase
   end

   // One nibble step of a + ~b + carry; diffNext is diff with the current nibble written in.
   always_comb begin
      nibBase  = {idx, 2'b00};
      nibSum   = {1'b0, opA[nibBase +: 4]} + {1'b0, ~opB[nibBase +: 4]} + {4'b0000, carry};
      diffNext = diff;
      diffNext[nibBase +: 4] = nibSum[3:0];
   end

   // Datapath: latch operands on accept, step one nibble per RUN cycle, flags at the last step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: operand registers are reset too; they are only read in RUN, but this keeps them X-free.
         opA      <= '0;
         opB      <= '0;
         idx      <= '0;
         carry    <= 1'b1;
         diff     <= '0;
         borrow   <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         opA   <= a;
         opB   <= b;
         idx   <= '0;
         carry <= 1'b1;
         diff  <= '0;
      end else if (state == RUN) begin
         diff  <= diffNext;
         carry <= nibSum[4];
         idx   <= lastStep ? '0 : idx + 1'b1;
         if (lastStep) begin
            borrow   <= ~nibSum[4];
            zero     <= (diffNext == '0);
            negative <= diffNext[WIDTH-1];
            overflow <= (opA[WIDTH-1] ^ opB[WIDTH-1]) & (diffNext[WIDTH-1] ^ opA[WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_nibble_subtractor.sv
// Self-checking bench for nibble_subtractor: directed cases, back-to-back,
// ignored starts, mid-run reset, and random operands against an arithmetic model.
module tb_nibble_subtractor;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned NIB   = WIDTH / 4;

   typedef struct packed {
      logic [31:0] diff;
      logic        borrow;
      logic        zero;
      logic        negative;
      logic        overflow;
   } resultType;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] diff;
   logic        borrow;
   logic        zero;
   logic        negative;
   logic        overflow;

   int compareCount  = 0;
   int mismatchCount = 0;
   int doneCount     = 0;

   nibble_subtractor #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .borrow   (borrow),
      .zero     (zero),
      .negative (negative),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Count done pulses just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (done) doneCount++;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic on the full operands.
   function automatic resultType refModel(input logic [31:0] x, input logic [31:0] y);
      resultType r;
      longint    sd;
      sd         = longint'($signed(x)) - longint'($signed(y));
      r.diff     = x - y;
      r.borrow   = (x < y);
      r.zero     = (r.diff == 32'd0);
      r.negative = r.diff[31];
      r.overflow = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return r;
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic startOp(input logic [31:0] x, input logic [31:0] y);
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      checkValue("busyAfterAccept", {31'd0, busy}, 32'd1);
      checkValue("diffClearedOnAccept", diff, 32'd0);
   endtask

   // Counts edges after the accept until done; operands are scrambled meanwhile.
   task automatic waitDone(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         a = $urandom;
         b = $urandom;
         if (!done && cycles < NIB) checkValue("busyDuringRun", {31'd0, busy}, 32'd1);
      end while (!done && cycles < 50);
   endtask

   task automatic checkResult(input logic [31:0] x, input logic [31:0] y);
      resultType r;
      r = refModel(x, y);
      checkValue("doneHigh", {31'd0, done}, 32'd1);
      checkValue("busyLowInDone", {31'd0, busy}, 32'd0);
      checkValue("diff", diff, r.diff);
      checkValue("flags", {28'd0, borrow, zero, negative, overflow},
                 {28'd0, r.borrow, r.zero, r.negative, r.overflow});
   endtask

   task automatic runOp(input logic [31:0] x, input logic [31:0] y);
      int cycles;
      startOp(x, y);
      waitDone(cycles);
      checkValue("latency", cycles, NIB);
      checkResult(x, y);
   endtask

   initial begin
      int        cycles;
      int        baseCount;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] held;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(negedge clk);
      checkValue("resetBusy", {31'd0, busy}, 32'd0);
      checkValue("resetDone", {31'd0, done}, 32'd0);
      checkValue("resetDiff", diff, 32'd0);
      checkValue("resetFlags", {28'd0, borrow, zero, negative, overflow}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      runOp(32'd5, 32'd3);
      checkValue("diff5minus3", diff, 32'h0000_0002);
      runOp(32'd3, 32'd5);
      checkValue("diff3minus5", diff, 32'hFFFF_FFFE);
      checkValue("borrow3minus5", {31'd0, borrow}, 32'd1);
      runOp(32'h8000_0000, 32'd1);
      checkValue("overflowMinInt", {31'd0, overflow}, 32'd1);
      runOp(32'h1234_ABCD, 32'h1234_ABCD);
      checkValue("zeroEqual", {31'd0, zero}, 32'd1);

      // Back-to-back: start held during DONE.
      startOp(32'h10, 32'h01);
      checkValue("zeroHeldAfterAccept", {31'd0, zero}, 32'd1);
      waitDone(cycles);
      checkValue("latencyBackToBack", cycles, NIB);
      checkResult(32'h10, 32'h01);
      checkValue("diffBackToBack", diff, 32'h0000_000F);
      @(negedge clk);
      checkValue("doneOneCycle", {31'd0, done}, 32'd0);
      checkValue("diffHoldIdle", diff, 32'h0000_000F);

      // Start pulses during RUN are ignored.
      baseCount = doneCount;
      x = 32'hDEAD_BEEF;
      y = 32'h0BAD_F00D;
      startOp(x, y);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         start = !done && (cycles == 2 || cycles == 5);
         a     = $urandom;
         b     = $urandom;
      end while (!done && cycles < 50);
      start = 1'b0;
      checkValue("latencyIgnoredStarts", cycles, NIB);
      checkResult(x, y);
      repeat (3) @(negedge clk);
      checkValue("singleDonePulse", doneCount - baseCount, 32'd1);
      checkValue("idleAfterIgnored", {31'd0, busy}, 32'd0);

      // Reset mid-RUN aborts.
      baseCount = doneCount;
      startOp(32'hFFFF_0000, 32'd1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checkValue("abortBusy", {31'd0, busy}, 32'd0);
      checkValue("abortDone", {31'd0, done}, 32'd0);
      checkValue("abortDiff", diff, 32'd0);
      checkValue("abortFlags", {28'd0, borrow, zero, negative, overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checkValue("noDoneAfterAbort", doneCount - baseCount, 32'd0);
      runOp(32'd10, 32'd10);
      checkValue("zeroAfterAbort", {31'd0, zero}, 32'd1);

      // Random operands, with some equal and some small pairs.
      for (int i = 0; i < 24; i++) begin
         x = $urandom;
         y = $urandom;
         if (i % 5 == 0) y = x;
         if (i % 7 == 1) begin
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
         end
         runOp(x, y);
         held = diff;
         @(negedge clk);
         checkValue("randomDiffHold", diff, held);
         checkValue("randomDoneDrop", {31'd0, done}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/nibble_subtractor.md
# nibble_subtractor

Multi-cycle subtractor that computes A − B by processing one 4-bit nibble per clock, LSB nibble first, with a borrow carried between cycles in a register. It sits beside the 4-bit lookahead adder in the ALU datapath. It gives the ALU a subtract path with a start/done handshake, plus status flags for compare and branch logic.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of 4 and ≥ 8
- NIB (localparam), WIDTH/4, number of nibble steps
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled on rising edge; accepted only in IDLE or DONE
- a  in  WIDTH  minuend; sampled only on an accepted start
- b  in  WIDTH  subtrahend; sampled only on an accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; high in the cycle after the last nibble is written
- diff  out  WIDTH  result a − b (mod 2^WIDTH)
- borrow  out  1  1 when a < b unsigned
- zero  out  1  1 when diff == 0
- negative  out  1  diff[WIDTH-1]
- overflow  out  1  signed overflow of a − b

## Operation
- Subtraction is computed as a + ~b + 1:
  - The carry register is initialised to 1 on accept.
  - Each step adds a_nib + ~b_nib + carry, writes the 4-bit sum into diff[4i+3:4i], and stores the nibble carry-out as the new carry.
- States:
  - IDLE: busy=0, done=0. An accepted start goes to RUN. It latches a and b into internal operand registers, sets the nibble index i=0 and carry=1, and clears diff to 0.
  - RUN: busy=1. Each cycle processes nibble i, then increments i. On the step with i==NIB−1, go to DONE and update the flags.
  - DONE: done=1, busy=0, lasts exactly one cycle. With start=1, go directly to RUN with the new operands (back-to-back). Otherwise go to IDLE.
- Flags are registered at the final nibble step, from the final carry and the complete diff:
  - borrow = ~carry_out
  - zero = (diff == 0)
  - negative = diff[WIDTH-1]
  - overflow = (a[W-1] ≠ b[W-1]) & (diff[W-1] ≠ a[W-1])
- diff and the flags hold their values until the next accepted start. On an accepted start, diff clears to 0 and the flags hold until the final step.
- start is ignored while in RUN. Changes on a and b after accept have no effect.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, negative=0, overflow=0, carry=1, i=0.
- Reset asserted mid-RUN aborts the operation. No done is produced. All outputs take their reset values in the same cycle.
- Let start be accepted at edge k:
  - busy is high from edge k to edge k+NIB.
  - Nibble i is written at edge k+1+i.
  - The final nibble and the flags are written at edge k+NIB.
  - done is high for the cycle between edges k+NIB and k+NIB+1.
- Total latency from start sample to done rising is NIB edges. The default is 8.
- Throughput with back-to-back start during DONE is one result per NIB+1 cycles.
- During RUN, diff shows a partial result: nibbles below i are valid, the upper nibbles are 0. Consumers must only use diff while done=1 or while in IDLE afterwards.

## Test plan
- WIDTH=32, a=5, b=3, start one cycle:
  - done asserts exactly 8 edges after the start sample.
  - diff=0x00000002; borrow=0, zero=0, negative=0, overflow=0.
- a=3, b=5:
  - diff=0xFFFFFFFE.
  - borrow=1, negative=1, overflow=0, zero=0.
- a=0x80000000, b=1:
  - diff=0x7FFFFFFF.
  - overflow=1, borrow=0, negative=0.
- a=b=0x1234ABCD:
  - diff=0, zero=1, borrow=0.
  - Then start held high during DONE with a=0x10, b=0x01. A second done appears 8 edges after DONE, with diff=0x0000000F.
- Pulse start=1 at RUN cycles 2 and 5 with different operands:
  - Both requests are ignored.
  - The result matches the original operands and exactly one done pulse is produced.
- Assert rst at RUN cycle 4 of a=0xFFFF0000, b=1:
  - All outputs go to 0 immediately, with no done.
  - After release, a new start with a=10, b=10 gives diff=0 and zero=1 after 8 edges.
